// File: rtl/axisv_pkg.sv
// axisv_pkg: shared types and framing helper for axisv stream blocks
package axisv_pkg;

    typedef enum logic [1:0] {SEEK, WAIT_FRAME, LOCKED} sink_state_e;

    typedef struct packed {
        logic tuser;
        logic tlast;
    } framing_t;

    function automatic framing_t expected_framing(
        input int unsigned h,
        input int unsigned v,
        input int unsigned h_pixels,
        input int unsigned v_pixels
    );
        framing_t f;
        f.tlast = (h == h_pixels - 1);
        f.tuser = f.tlast && (v == v_pixels - 1);
        return f;
    endfunction

endpackage

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: free-running raster counters with region flags
module lcd_timing_gen #(
    parameter int H_PIXEL_COUNT = 8,
    parameter int V_PIXEL_COUNT = 4,
    parameter int H_FRONT_PORCH = 2,
    parameter int H_SYNC        = 2,
    parameter int H_BACK_PORCH  = 2,
    parameter int V_FRONT_PORCH = 1,
    parameter int V_SYNC        = 1,
    parameter int V_BACK_PORCH  = 1,
    localparam int H_TOTAL = H_PIXEL_COUNT + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH,
    localparam int V_TOTAL = V_PIXEL_COUNT + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH,
    localparam int HW = $clog2(H_TOTAL),
    localparam int VW = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          last_cycle
);

    logic h_wrap;
    logic v_wrap;

    // Region flags decoded straight from the counters
    always_comb begin
        h_wrap     = 32'(h) == H_TOTAL - 1;
        v_wrap     = 32'(v) == V_TOTAL - 1;
        active     = 32'(h) < H_PIXEL_COUNT && 32'(v) < V_PIXEL_COUNT;
        hsync      = 32'(h) >= H_PIXEL_COUNT + H_FRONT_PORCH && 32'(h) < H_PIXEL_COUNT + H_FRONT_PORCH + H_SYNC;
        vsync      = 32'(v) >= V_PIXEL_COUNT + V_FRONT_PORCH && 32'(v) < V_PIXEL_COUNT + V_FRONT_PORCH + V_SYNC;
        last_cycle = h_wrap && v_wrap;
    end

    // Raster counters never stall; v advances when h wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else begin
            h <= h_wrap ? '0 : h + HW'(1);
            if (h_wrap) v <= v_wrap ? '0 : v + VW'(1);
        end
    end

endmodule

// File: rtl/axisv_lcd_sink.sv
// axisv_lcd_sink: axisv stream sink driving a parallel LCD with frame lock and resync
module axisv_lcd_sink
    import axisv_pkg::*;
#(
    parameter int H_PIXEL_COUNT = 8,
    parameter int V_PIXEL_COUNT = 4,
    parameter int H_FRONT_PORCH = 2,
    parameter int H_SYNC        = 2,
    parameter int H_BACK_PORCH  = 2,
    parameter int V_FRONT_PORCH = 1,
    parameter int V_SYNC        = 1,
    parameter int V_BACK_PORCH  = 1,
    parameter int DATA_WIDTH    = 18,
    localparam int HW = $clog2(H_PIXEL_COUNT + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH),
    localparam int VW = $clog2(V_PIXEL_COUNT + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH)
) (
    input  logic                  aclk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [DATA_WIDTH-1:0] lcd_data_o,
    output logic                  lcd_de_o,
    output logic                  lcd_hsync_o,
    output logic                  lcd_vsync_o,
    output logic                  locked_o,
    output logic                  underflow_o,
    output logic                  framing_err_o
);

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          active;
    logic          hsync;
    logic          vsync;
    logic          last_cycle;
    sink_state_e   state;
    sink_state_e   state_nxt;
    framing_t      exp;
    logic          accept;
    logic          underflow;
    logic          framing_err;

    lcd_timing_gen #(
        .H_PIXEL_COUNT(H_PIXEL_COUNT),
        .V_PIXEL_COUNT(V_PIXEL_COUNT),
        .H_FRONT_PORCH(H_FRONT_PORCH),
        .H_SYNC       (H_SYNC),
        .H_BACK_PORCH (H_BACK_PORCH),
        .V_FRONT_PORCH(V_FRONT_PORCH),
        .V_SYNC       (V_SYNC),
        .V_BACK_PORCH (V_BACK_PORCH)
    ) u_timing (
        .clk       (aclk_i),
        .rst       (rst_i),
        .h         (h),
        .v         (v),
        .active    (active),
        .hsync     (hsync),
        .vsync     (vsync),
        .last_cycle(last_cycle)
    );

    // Handshake, framing checks and next state; errors drop straight back to SEEK
    always_comb begin
        exp           = expected_framing(32'(h), 32'(v), H_PIXEL_COUNT, V_PIXEL_COUNT);
        s_axis_tready = !rst_i && (state == SEEK || (state == LOCKED && active));
        accept        = s_axis_tvalid && s_axis_tready;
        underflow     = state == LOCKED && active && !s_axis_tvalid;
        framing_err   = state == LOCKED && accept && (s_axis_tlast != exp.tlast || s_axis_tuser != exp.tuser);
        state_nxt     = state == SEEK       ? (accept && s_axis_tuser ? WAIT_FRAME : SEEK) :
                        state == WAIT_FRAME ? (last_cycle ? LOCKED : WAIT_FRAME) :
                                              (underflow || framing_err ? SEEK : LOCKED);
    end

    // State register
    always_ff @(posedge aclk_i) begin
        if (rst_i) state <= SEEK;
        else state <= state_nxt;
    end

    // Panel and status registers, one cycle behind the raster
    always_ff @(posedge aclk_i) begin
        if (rst_i) begin
            lcd_data_o    <= '0;
            lcd_de_o      <= 1'b0;
            lcd_hsync_o   <= 1'b0;
            lcd_vsync_o   <= 1'b0;
            locked_o      <= 1'b0;
            underflow_o   <= 1'b0;
            framing_err_o <= 1'b0;
        end else begin
            lcd_data_o    <= state == LOCKED && accept ? s_axis_tdata : '0;
            lcd_de_o      <= active;
            lcd_hsync_o   <= hsync;
            lcd_vsync_o   <= vsync;
            locked_o      <= state_nxt == LOCKED;
            underflow_o   <= underflow;
            framing_err_o <= framing_err;
        end
    end

endmodule

// File: doc/axisv_lcd_sink.md
# axisv_lcd_sink

AXI4-Stream video sink that consumes pixel frames and drives a parallel LCD panel with free-running raster timing (data, DE, HSYNC, VSYNC). It sits downstream of the stream-side video sources, such as the test pattern generator and DMA readers, and is the display end of the `axisv` interface. Framing follows the `axisv` convention: `tlast` marks the last pixel of a line, and `tuser[0]` marks the last pixel of a frame. The block locks onto frame boundaries, paces the stream with `tready`, and falls back to resynchronisation on underflow or framing error.

## Interface
- `H_PIXEL_COUNT`, 8, active pixels per line
- `V_PIXEL_COUNT`, 4, active lines per frame
- `H_FRONT_PORCH`, 2, cycles between active pixels and HSYNC
- `H_SYNC`, 2, HSYNC width in cycles
- `H_BACK_PORCH`, 2, cycles from HSYNC to the next line
- `V_FRONT_PORCH`, 1, lines between active video and VSYNC
- `V_SYNC`, 1, VSYNC width in lines
- `V_BACK_PORCH`, 1, lines from VSYNC to the next frame
- `DATA_WIDTH`, 18, pixel width
- `aclk_i` in 1: the only clock
- `rst_i` in 1: synchronous, active-high reset
- `s_axis_tdata` in DATA_WIDTH: pixel
- `s_axis_tvalid` in 1
- `s_axis_tready` out 1
- `s_axis_tlast` in 1: end of line
- `s_axis_tuser` in 1: bit 0 is end of frame
- `lcd_data_o` out DATA_WIDTH: panel pixel data
- `lcd_de_o` out 1: data enable, active-high
- `lcd_hsync_o` out 1: active-high
- `lcd_vsync_o` out 1: active-high
- `locked_o` out 1: high in state LOCKED
- `underflow_o` out 1: one-cycle pulse
- `framing_err_o` out 1: one-cycle pulse

## Operation
- **Raster totals:** H_TOTAL = H_PIXEL_COUNT + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH. V_TOTAL is defined the same way from the vertical parameters.
- **Counters:** `h` wraps at H_TOTAL−1 and then increments `v`. `v` wraps at V_TOTAL−1. Counter width is $clog2(TOTAL).
- **Free-running raster:** the counters run from the cycle after reset release and are never stalled by the stream.
- **Region order within each axis:** active, then front porch, then sync, then back porch.
  - `active` = (h < H_PIXEL_COUNT) && (v < V_PIXEL_COUNT).
  - hsync is asserted for h in [H_PIXEL_COUNT+H_FRONT_PORCH, +H_SYNC).
  - vsync is asserted for whole lines with v in [V_PIXEL_COUNT+V_FRONT_PORCH, +V_SYNC).
- **State machine (`SEEK`, `WAIT_FRAME`, `LOCKED`):**
  - **SEEK:** `tready`=1 and all beats are discarded. An accepted beat with `tuser[0]`=1 moves the block to WAIT_FRAME.
  - **WAIT_FRAME:** `tready`=0. On the last raster cycle (h=H_TOTAL−1, v=V_TOTAL−1) the block moves to LOCKED.
  - **LOCKED:** `tready` = `active`.
- **Checks in LOCKED on an active cycle:**
  - **`tvalid`=0 (underflow):** pulse `underflow_o`, output pixel 0, go to SEEK.
  - **Accepted beat:**
    - Expected `tlast` = (h == H_PIXEL_COUNT−1).
    - Expected `tuser[0]` = expected `tlast` && (v == V_PIXEL_COUNT−1).
    - Any mismatch: pulse `framing_err_o`, still display the pixel, go to SEEK.
- Underflow and framing error are mutually exclusive, because underflow has no beat.
- **Display outside LOCKED:** `lcd_data_o`=0 whenever the block is not LOCKED or the cycle is not active. DE, HSYNC and VSYNC follow the raster in every state.

## Timing
- **Reset values:** all outputs 0. State = SEEK, h=0, v=0. `s_axis_tready` is forced 0 while `rst_i` is high.
- **`s_axis_tready`:** combinational from the state and the current counters. It has no dependency on `tvalid`.
- **LCD outputs:** `lcd_*` are registered and reflect the raster and handshake of the previous cycle, so latency is 1 cycle from beat acceptance to `lcd_data_o`.
- **Status outputs:** `underflow_o` and `framing_err_o` are registered and are high for the cycle after the offending cycle. `locked_o` is registered from the state.
- **Resync on error:** the state change after an error is effective on the next cycle, so the next `tready` comes from SEEK.
- **Reset mid-frame:** counters, state and outputs return to their reset values. Any partial frame is dropped via SEEK.
- **Frame length with defaults:** H_TOTAL=14 and V_TOTAL=7, giving a 98-cycle frame.

## Structure
- **Package `axisv_pkg`:**
  - state enum `sink_state_e` (SEEK, WAIT_FRAME, LOCKED);
  - a shared function that computes the expected `tlast`/`tuser` from (h, v, H_PIXEL_COUNT, V_PIXEL_COUNT), reusable by video sources.
- **Sub-module `lcd_timing_gen`:** contains the raster counters plus the `active`, `hsync`, `vsync` and `last_cycle` flags, all combinational from the counters.
- **Top level:** contains the FSM, handshake, checks and output registers.

## Test plan
- **Clean frames:** reset, then source sends two clean frames with `tvalid` held at 1 and the correct framing.
  - First frame: drained in SEEK; `locked_o` rises 1 cycle after the raster cycle h=13, v=6.
  - Second frame: 32 pixels are displayed with `lcd_de_o` on exactly 32 cycles, and `lcd_data_o` equals the beat data 1 cycle after acceptance.
- **Raster timing (defaults):** `lcd_hsync_o` is high on h=10..11 of every line. `lcd_vsync_o` is high for all 14 cycles of v=5. `lcd_de_o` is high for 8 cycles on lines v=0..3.
- **Underflow:** while LOCKED, drop `tvalid` at h=3, v=1.
  - That cycle: `underflow_o` pulses once, `lcd_data_o`=0.
  - Recovery: state returns to SEEK and relocks after the next EOF beat.
- **Early `tlast`:** assert `tlast` at h=5 → `framing_err_o` pulses, the pixel is still shown, the block returns to SEEK, and `locked_o` falls.
- **Missing EOF:** `tuser[0]` is 0 on pixel h=7, v=3 → `framing_err_o` pulses.
- **Mid-frame reset:** assert `rst_i` at h=4, v=2 → all outputs 0 and `tready`=0 during reset. After release the first cycle is h=0, v=0 with `tready`=1 (SEEK).
